// File: rtl/dpram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_pkg : shared types and sizing helpers for dpram_bw             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dpram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } clr_state_t;

   function automatic int calc_nb(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

   // Address width never collapses to zero, even for one- or two-word memories.
   function automatic int calc_aw(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic bit latency_ok(input int read_latency);
      return (read_latency == 1) || (read_latency == 2);
   endfunction

   function automatic bit width_ok(input int data_width, input int byte_width);
      return (byte_width > 0) && ((data_width % byte_width) == 0);
   endfunction

endpackage : dpram_pkg
`default_nettype wire

// File: rtl/dpram_bw_outpipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_bw_outpipe : per-port data/valid delay line, 1 or 2 stages     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dpram_bw_outpipe #(
   parameter int WIDTH        = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_data;

   // Data only moves on a valid beat so the output holds between strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_data <= in_data;
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic             r_s2_valid;
         logic [WIDTH-1:0] r_s2_data;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_s2_valid <= 1'b0;
               r_s2_data  <= '0;
            end else begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_s2_data <= r_s1_data;
               end
            end
         end

         assign out_valid = r_s2_valid;
         assign out_data  = r_s2_data;
      end else begin : g_lat1
         assign out_valid = r_s1_valid;
         assign out_data  = r_s1_data;
      end
   endgenerate

endmodule : dpram_bw_outpipe
`default_nettype wire

// File: rtl/dpram_bw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_bw : true dual-port RAM, byte enables, collision flag, clear   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dpram_bw
   import dpram_pkg::*;
#(
   parameter  int DATA_WIDTH     = 32,
   parameter  int BYTE_WIDTH     = 8,
   parameter  int RAM_DEPTH      = 256,
   parameter  int READ_LATENCY   = 1,
   parameter  int CLEAR_ON_RESET = 1,
   localparam int NB             = calc_nb(DATA_WIDTH, BYTE_WIDTH),
   localparam int AW             = calc_aw(RAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  ready,
   input  logic                  ena,
   input  logic [NB-1:0]         wea,
   input  logic [AW-1:0]         addra,
   input  logic [DATA_WIDTH-1:0] dina,
   output logic [DATA_WIDTH-1:0] douta,
   output logic                  douta_valid,
   input  logic                  enb,
   input  logic [NB-1:0]         web,
   input  logic [AW-1:0]         addrb,
   input  logic [DATA_WIDTH-1:0] dinb,
   output logic [DATA_WIDTH-1:0] doutb,
   output logic                  doutb_valid,
   output logic                  collision
);

   generate
      if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
         $error("dpram_bw: READ_LATENCY must be 1 or 2");
      end
      if (!width_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
         $error("dpram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

   clr_state_t            r_state;
   clr_state_t            w_state_nxt;
   logic [AW-1:0]         r_clr_cnt;
   logic [AW-1:0]         w_clr_cnt_nxt;
   logic                  r_ready;

   logic                  w_acc_a;
   logic                  w_acc_b;
   logic                  w_inr_a;
   logic                  w_inr_b;
   logic                  w_coll;
   logic                  w_wr_a;
   logic                  w_wr_b;
   logic [DATA_WIDTH-1:0] w_old_a;
   logic [DATA_WIDTH-1:0] w_old_b;
   logic [DATA_WIDTH-1:0] w_new_a;
   logic [DATA_WIDTH-1:0] w_new_b;
   logic [DATA_WIDTH-1:0] w_rd_a;
   logic [DATA_WIDTH-1:0] w_rd_b;
   logic                  w_coll_held;

   // ---------------- clear sequencer ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         r_clr_cnt <= '0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
         r_ready   <= (w_state_nxt == ST_READY);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         ST_CLEAR: begin
            w_clr_cnt_nxt = r_clr_cnt + AW'(1);
            if (r_clr_cnt == AW'(RAM_DEPTH - 1)) begin
               w_state_nxt   = ST_READY;
               w_clr_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_READY;
         end
      endcase
   end

   assign ready = r_ready;

   // ---------------- address range ----------------
   generate
      if ((1 << AW) == RAM_DEPTH) begin : g_pow2
         assign w_inr_a = 1'b1;
         assign w_inr_b = 1'b1;
      end else begin : g_npow2
         assign w_inr_a = (addra < AW'(RAM_DEPTH));
         assign w_inr_b = (addrb < AW'(RAM_DEPTH));
      end
   endgenerate

   // ---------------- access, merge and arbitration ----------------
   always_comb begin
      w_acc_a = ena & r_ready;
      w_acc_b = enb & r_ready;
      w_coll  = w_acc_a & w_acc_b & (addra == addrb);
      w_old_a = w_inr_a ? r_mem[addra] : '0;
      w_old_b = w_inr_b ? r_mem[addrb] : '0;
      w_new_a = w_old_a;
      w_new_b = w_old_b;
      // On a shared address both merges resolve to the same word, A winning each lane.
      for (int i = 0; i < NB; i++) begin
         if (wea[i]) begin
            w_new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         end else if (w_coll && web[i]) begin
            w_new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
         if (w_coll && wea[i]) begin
            w_new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         end else if (web[i]) begin
            w_new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      w_wr_a  = w_acc_a & (|wea) & w_inr_a & rst_n;
      w_wr_b  = w_acc_b & (|web) & w_inr_b & rst_n;
      w_rd_a  = '0;
      w_rd_b  = '0;
      if (w_inr_a) begin
         w_rd_a = (|wea) ? w_new_a : w_old_a;
      end
      if (w_inr_b) begin
         w_rd_b = (|web) ? w_new_b : w_old_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && (r_state == ST_CLEAR)) begin
         r_mem[r_clr_cnt] <= '0;
      end
      if (w_wr_a) begin
         r_mem[addra] <= w_new_a;
      end
      if (w_wr_b) begin
         r_mem[addrb] <= w_new_b;
      end
   end

   // ---------------- output pipes ----------------
   // The collision flag rides along with port A so it lines up with douta_valid.
   dpram_bw_outpipe #(
      .WIDTH        (DATA_WIDTH + 1),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_acc_a),
      .in_data   ({w_coll, w_rd_a}),
      .out_valid (douta_valid),
      .out_data  ({w_coll_held, douta})
   );

   dpram_bw_outpipe #(
      .WIDTH        (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_acc_b),
      .in_data   (w_rd_b),
      .out_valid (doutb_valid),
      .out_data  (doutb)
   );

   assign collision = douta_valid & w_coll_held;

endmodule : dpram_bw
`default_nettype wire

// File: tb/tb_dpram_bw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dpram_bw : scoreboard bench, two dpram_bw configurations          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dpram_bw;

   localparam int DW = 32;
   localparam int NB = 4;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en_a0 = 1'b0, en_b0 = 1'b0, en_a1 = 1'b0, en_b1 = 1'b0;
   logic [NB-1:0] wea = '0, web = '0;
   logic [AW-1:0] addra = '0, addrb = '0;
   logic [DW-1:0] dina = '0, dinb = '0;

   logic          rdy  [2];
   logic [DW-1:0] da   [2];
   logic [DW-1:0] db   [2];
   logic          va   [2];
   logic          vb   [2];
   logic          col  [2];

   always #5 clk = ~clk;

   // dut0: power-of-two depth, two-cycle latency, cleared after reset
   dpram_bw #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .RAM_DEPTH(16),
              .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .ready(rdy[0]),
      .ena(en_a0), .wea(wea), .addra(addra), .dina(dina),
      .douta(da[0]), .douta_valid(va[0]),
      .enb(en_b0), .web(web), .addrb(addrb), .dinb(dinb),
      .doutb(db[0]), .doutb_valid(vb[0]), .collision(col[0]));

   // dut1: non-power-of-two depth, single-cycle latency, no clear
   dpram_bw #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .RAM_DEPTH(12),
              .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .ready(rdy[1]),
      .ena(en_a1), .wea(wea), .addra(addra), .dina(dina),
      .douta(da[1]), .douta_valid(va[1]),
      .enb(en_b1), .web(web), .addrb(addrb), .dinb(dinb),
      .doutb(db[1]), .doutb_valid(vb[1]), .collision(col[1]));

   typedef struct {
      logic [DW-1:0] d;
      logic          c;
      int            due;
   } exp_t;

   exp_t          sb [4][$];
   logic [DW-1:0] mdl [2][16];
   int            depth [2] = '{16, 12};
   int            lat   [2] = '{2, 1};
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                           input logic [DW-1:0] din,
                                           input logic [NB-1:0] we);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < NB; i++)
         if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
      return r;
   endfunction

   // Reference behaviour of one memory for the access pattern currently on the pins.
   task automatic model_step(input int k, input logic ea, input logic eb);
      logic          coll, ina, inb;
      logic [DW-1:0] olda, oldb, na, nb, ea_d, eb_d;
      coll = ea && eb && (addra == addrb);
      ina  = int'(addra) < depth[k];
      inb  = int'(addrb) < depth[k];
      olda = ina ? mdl[k][addra] : '0;
      oldb = inb ? mdl[k][addrb] : '0;
      if (coll) begin
         na = merge(merge(olda, dinb, web), dina, wea);
         nb = na;
      end else begin
         na = merge(olda, dina, wea);
         nb = merge(oldb, dinb, web);
      end
      ea_d = !ina ? '0 : ((wea != 0) ? na : olda);
      eb_d = !inb ? '0 : ((web != 0) ? nb : oldb);
      if (ea && ina && wea != 0) mdl[k][addra] = na;
      if (eb && inb && web != 0) mdl[k][addrb] = nb;
      if (ea) sb[2*k].push_back('{ea_d, coll, cyc + lat[k]});
      if (eb) sb[2*k+1].push_back('{eb_d, 1'b0, cyc + lat[k]});
   endtask

   task automatic drive(input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] dda, input logic eb, input logic [NB-1:0] wb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] ddb,
                        input bit use0, input bit use1);
      wea = wa; addra = aa; dina = dda;
      web = wb; addrb = ab; dinb = ddb;
      en_a0 = ea; en_b0 = eb;
      en_a1 = use1 ? ea : 1'b0;
      en_b1 = use1 ? eb : 1'b0;
      if (use0) model_step(0, ea, eb);
      if (use1) model_step(1, ea, eb);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      en_a0 = 0; en_b0 = 0; en_a1 = 0; en_b1 = 0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Wait for dut0 ready after reset release, with stray requests that must be dropped.
   task automatic clear_phase(output int e0, output int e1);
      e0 = -1; e1 = -1;
      for (int t = 1; t <= 40 && e0 < 0; t++) begin
         wea = NB'($urandom); addra = AW'($urandom); dina = $urandom;
         web = NB'($urandom); addrb = AW'($urandom); dinb = $urandom;
         en_a0 = 1'($urandom); en_b0 = 1'($urandom);
         en_a1 = 0; en_b1 = 0;
         @(posedge clk); #1;
         if (rdy[1] && e1 < 0) e1 = t;
         if (rdy[0]) e0 = t;
      end
      en_a0 = 0; en_b0 = 0;
   endtask

   // Monitor: pops expected beats whenever a port strobes.
   always @(negedge clk) begin : mon
      exp_t          e;
      logic          v, c;
      logic [DW-1:0] d;
      int            k;
      for (int p = 0; p < 4; p++) begin
         k = p / 2;
         v = (p % 2 == 0) ? va[k] : vb[k];
         d = (p % 2 == 0) ? da[k] : db[k];
         c = (p % 2 == 0) ? col[k] : 1'b0;
         if (v === 1'b1) begin
            n_cmp++;
            if (sb[p].size() == 0) begin
               n_err++;
               $display("FAIL unexpected_strobe port%0d cyc=%0d data=%h", p, cyc, d);
            end else begin
               e = sb[p].pop_front();
               if (d !== e.d || cyc != e.due || c !== e.c) begin
                  n_err++;
                  $display("FAIL strobe port%0d got data=%h coll=%b cyc=%0d want data=%h coll=%b cyc=%0d",
                           p, d, c, cyc, e.d, e.c, e.due);
               end
            end
         end else if (p % 2 == 0 && col[k] === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_collision dut%0d cyc=%0d got=1 want=0", k, cyc);
         end
      end
   end

   initial begin : stim
      int e0, e1;
      logic [DW-1:0] v;
      #1;
      for (int i = 0; i < 16; i++) begin
         dut0.r_mem[i] = $urandom;
         mdl[0][i] = '0;
         mdl[1][i] = '0;
      end
      for (int i = 0; i < 12; i++) begin
         v = $urandom;
         dut1.r_mem[i] = v;
         mdl[1][i] = v;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset_ready%0d", k), 32'(rdy[k]), 0);
         chk($sformatf("reset_douta%0d", k), da[k], 0);
         chk($sformatf("reset_doutb%0d", k), db[k], 0);
         chk($sformatf("reset_valid%0d", k), 32'({va[k], vb[k], col[k]}), 0);
      end

      rst_n = 1;
      clear_phase(e0, e1);
      chk("clear_edges_dut0", e0, 16);
      chk("ready_edges_dut1", e1, 1);

      // Every word of dut0 reads back zero; dut1 returns preload or zero out of range.
      for (int i = 0; i < 16; i++)
         drive(1, 0, AW'(i), 0, 1, 0, AW'(15 - i), 0, 1, 1);
      idle(3);

      // Partial-byte update
      drive(1, 4'hF, 5, 32'hAABBCCDD, 0, 0, 0, 0, 1, 1);
      drive(1, 4'b0101, 5, 32'h11223344, 0, 0, 0, 0, 1, 1);
      drive(1, 0, 5, 0, 0, 0, 0, 0, 1, 1);
      idle(2);

      // Both ports write address 3
      drive(1, 4'b0001, 3, 32'h000000FF, 1, 4'b1111, 3, 32'hFFFFFF00, 1, 1);
      drive(1, 0, 3, 0, 0, 0, 0, 0, 1, 1);
      idle(2);

      // Read-first across ports
      drive(1, 4'hF, 7, 32'h1, 0, 0, 0, 0, 1, 1);
      drive(1, 4'hF, 7, 32'h2, 1, 0, 7, 0, 1, 1);
      drive(0, 0, 0, 0, 1, 0, 7, 0, 1, 1);
      idle(2);

      // Both read the same address
      drive(1, 0, 9, 0, 1, 0, 9, 0, 1, 1);
      // Back-to-back reads
      for (int i = 0; i < 4; i++)
         drive(1, 0, AW'(i), 0, 1, 0, AW'(i), 0, 1, 1);
      idle(3);

      for (int n = 0; n < 300; n++) begin
         logic [AW-1:0] a, b;
         a = AW'($urandom);
         b = ($urandom_range(0, 3) == 0) ? a : AW'($urandom);
         drive(1'($urandom), ($urandom_range(0, 1) != 0) ? 4'h0 : NB'($urandom), a, $urandom,
               1'($urandom), ($urandom_range(0, 1) != 0) ? 4'h0 : NB'($urandom), b, $urandom,
               1, 1);
      end
      idle(4);

      // Reset on the edge after an accepted read: dut0 must never strobe it.
      drive(1, 0, 2, 0, 0, 0, 0, 0, 0, 1);
      rst_n = 0;
      en_a0 = 0; en_a1 = 0;
      @(posedge clk); #1;
      chk("midreset_ready0", 32'(rdy[0]), 0);
      chk("midreset_ready1", 32'(rdy[1]), 0);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) mdl[0][i] = '0;
      rst_n = 1;
      clear_phase(e0, e1);
      chk("reclear_edges_dut0", e0, 16);
      chk("reready_edges_dut1", e1, 1);
      for (int i = 0; i < 16; i++)
         drive(1, 0, AW'(i), 0, 0, 0, 0, 0, 1, 1);
      idle(4);

      for (int p = 0; p < 4; p++)
         chk($sformatf("leftover_port%0d", p), sb[p].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_dpram_bw
`default_nettype wire

// File: doc/dpram_bw.md
# dpram_bw

Single-clock true dual-port RAM with per-byte write enables, selectable 1- or 2-cycle read latency, and valid-tagged read data. It also detects same-address collisions between ports and can sweep-clear the memory after reset. It replaces the plain dual-port RAM wherever DMA descriptor and buffer storage needs partial-word updates and explicit data-valid timing.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- RAM_DEPTH, 256, number of words; AW = $clog2(RAM_DEPTH), minimum 1
- READ_LATENCY, 1, accept-to-valid cycles; legal values 1 or 2
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting accesses

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- ready  out  1  ports accept accesses only when high
- ena / enb  in  1  port A / B access request
- wea / web  in  NB  per-byte write enable; all zero = read
- addra / addrb  in  AW  word address
- dina / dinb  in  DATA_WIDTH  write data
- douta / doutb  out  DATA_WIDTH  read/write-back data
- douta_valid / doutb_valid  out  1  one-cycle strobe marking new dout
- collision  out  1  one-cycle strobe on a same-address dual access

## Operation
- Clear FSM states: CLEAR, READY.
  - During reset: state = CLEAR if CLEAR_ON_RESET else READY; clear counter = 0.
  - CLEAR: writes zero to word `counter`, increments the counter, and moves to READY after writing word RAM_DEPTH-1.
  - READY: terminal state; only rst_n low leaves it.
- ready = (state == READY), registered.
- An access is accepted when en_x && ready. An en_x asserted while ready is low is dropped; it produces no valid strobe.
- Accepted write (any we bit set): only the enabled byte lanes are updated. dout presents the merged new word (write-first within a port), and dout_valid pulses.
- Accepted read: dout presents the stored word, and dout_valid pulses.
- Out-of-range address (≥ RAM_DEPTH, non-power-of-2 depth only): the write is ignored; the access still returns all zeros with dout_valid.
- Same address, both ports accepted in the same cycle:
  - collision pulses.
  - Both writing: for each byte, A wins if wea[i] is set, otherwise B's lane applies if web[i] is set. Each port's dout shows the final merged word.
  - One port writing, one reading: the reader gets the pre-write contents (read-first across ports); the writer gets the new word.
  - Both reading: collision still pulses and both ports get the same data.
- dout holds its last value between strobes. It is never cleared except by reset.
- Reset mid-operation: in-flight valid pipeline stages are flushed and no strobe is emitted for accepted-but-pending reads. If CLEAR_ON_RESET = 1, the clear restarts from address 0.

## Timing
- Reset values: ready 0 (CLEAR_ON_RESET = 1) or 0 during reset and 1 from the first edge with rst_n high (CLEAR_ON_RESET = 0); douta/doutb 0; douta_valid/doutb_valid 0; collision 0.
- Clear duration: the edge at which rst_n is first sampled high writes word 0. ready is high after RAM_DEPTH such edges, so the first access can be accepted on the next edge.
- READ_LATENCY = 1: an access accepted at edge N gives dout and dout_valid registered at edge N.
- READ_LATENCY = 2: the same outputs appear one edge later (N+1), through an output register.
- Both settings are fully pipelined: one access per port per cycle, back-to-back strobes.
- collision uses the same latency as dout_valid and aligns with the affected strobes.

## Structure
- Package dpram_pkg holds:
  - clear-FSM state enum (ST_CLEAR, ST_READY)
  - localparam helpers for NB and AW
  - READ_LATENCY legality check (elaboration error if not 1 or 2)
- Sub-module dpram_bw_outpipe: per-port data/valid delay line parameterised by READ_LATENCY. It is instantiated twice, and collision shares port A's instance timing.
- The memory array plus byte-merge and arbitration logic stay in dpram_bw.

## Test plan
- Reset clear:
  - Stimulus: DEPTH 16, CLEAR_ON_RESET 1; preload with garbage via backdoor, then release rst_n.
  - Expected: ready rises after exactly 16 edges; reads of all 16 addresses return 0 with one strobe each.
- Byte write:
  - Stimulus: write 0xAABBCCDD to address 5; then write wea = 4'b0101, dina = 0x11223344; then read address 5.
  - Expected: the second write's dout is 0xAA22CC44; the read returns 0xAA22CC44.
- Collision:
  - Stimulus: same cycle, A writes 0x000000FF with we 4'b0001, B writes 0xFFFFFF00 with we 4'b1111, both at address 3.
  - Expected: stored value 0xFFFFFFFF; collision pulses once; both douts read 0xFFFFFFFF.
- Cross-port read-first:
  - Stimulus: address 7 holds 0x1; A writes 0x2 there while B reads it in the same cycle.
  - Expected: doutb = 0x1, douta = 0x2; a later read of address 7 returns 0x2.
- Latency and pipelining:
  - Stimulus: READ_LATENCY 2; back-to-back reads of addresses 0..3 on both ports.
  - Expected: four consecutive valid strobes per port, each two edges after its accept, with data in order.
- Reset mid-flight:
  - Stimulus: assert rst_n low on the edge after accepting a read with READ_LATENCY 2.
  - Expected: no valid strobe; ready drops, and the clear restarts from address 0.
